note_spi_tx: RTL and testbench
==============================

Name: note_spi_tx

Overview:
- SPI-slave transmitter that returns decoded note events from fft_ctrl to the MCU, which acts as SPI master.
- Captures each new_note pulse together with note and note_dur into a small FIFO.
- Serialises one event per chip-select frame on sdo; note_rdy asks the MCU to poll.
- Sits beside the inbound SPI byte receiver: same MCU link, opposite direction.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries (power of 2, minimum 2)
- NOTE_W, 8, width of note field
- DUR_W, 4, width of note_dur field
- SYNC_STAGES, 2, synchroniser flops on sck and spi_cs_n

Ports:
- clk_in  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- new_note  in  1  one-cycle event strobe from fft_ctrl
- note  in  NOTE_W  note code, valid when new_note=1
- note_dur  in  DUR_W  duration code, valid when new_note=1
- sck  in  1  SPI clock from MCU (async, mode 0, at most clk_in/8)
- spi_cs_n  in  1  SPI chip select, active low (async)
- sdo  out  1  SPI data to MCU, MSB first
- note_rdy  out  1  high while FIFO is non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries
- overflow  out  1  sticky flag: an event was dropped

Behaviour:
- Reset values: sdo=0, note_rdy=0, fifo_count=0, overflow=0, seq=0, FSM=IDLE. Reset mid-frame aborts the frame and empties the FIFO.
- Synchronisers: sck and spi_cs_n each pass through SYNC_STAGES flops. Edges are detected on the synchronised signals. All latency figures below are counted from the synchronised edge.
- Push: when new_note=1 and FIFO not full, store {note, note_dur, seq}, then seq <= seq+1 (2 bits, wraps 3->0).
- Push when full: the event is dropped, overflow<=1, seq is not incremented.
- Push and pop in the same cycle: both take effect, count unchanged. This holds when full: the pop frees a slot, so the push is accepted and overflow is not set.
- Frame word: byte0 = note; byte1 = {valid, ovf, seq[1:0], note_dur[3:0]}, 16 bits, MSB first.
- Empty FIFO at load: word is 0x0000 (valid=0), and nothing is popped at frame end.
- ovf field: a snapshot of overflow taken at load. If the frame completes, overflow is cleared, unless a new drop occurs in the same cycle, in which case it stays 1.
- FSM IDLE: sdo=0. A synchronised spi_cs_n falling edge moves to LOAD.
- FSM LOAD (1 cycle): shift register <= frame word (head entry, or idle word), sdo <= MSB, bitcnt=0, go to SHIFT.
- FSM SHIFT:
  - Each synchronised sck rising edge increments bitcnt.
  - Each synchronised sck falling edge shifts left and drives the next bit onto sdo.
  - At bitcnt=FRAME_BITS go to DONE.
  - A spi_cs_n rising edge before that aborts: return to IDLE with no pop, so the same entry is re-sent next frame.
- FSM DONE: hold sdo=0 and ignore sck. On the spi_cs_n rising edge, pop the head if valid was 1, then go to IDLE.
- note_rdy = (fifo_count != 0), registered.
- spi_cs_n falling within 1 cycle of reset release: ignored; the next falling edge is serviced.

Optional Feature:
- NOTE_TX_CRC_EN defined: FRAME_BITS=24. byte2 = CRC-8 (poly 0x07, init 0x00, no reflection) over byte0 then byte1, computed combinationally at LOAD.
- NOTE_TX_CRC_EN undefined: FRAME_BITS=16 and no CRC logic is present.

Decomposition:
- Package note_tx_pkg:
  - note_evt_t struct {note, dur, seq}
  - FRAME_BITS constant, set under the macro
  - CRC8_POLY=8'h07
  - FSM state enum {IDLE, LOAD, SHIFT, DONE}
- One sub-module, note_evt_fifo: synchronous FIFO with push/pop, full/empty, count, and simultaneous push/pop support.
- Synchronisers and FSM live in the top level.

Test Plan:
- Single event: push note=0x2A, dur=4'b0100, then run a 16-sck frame. Require sdo=0x2A,0x84, count 1->0, note_rdy falls after spi_cs_n rises.
- Empty poll: frame with FIFO empty -> sdo=0x0000, count stays 0, no underflow.
- Overflow: push 9 events with no reads (depth 8). Require the 9th dropped and overflow=1. First read byte1 has ovf=1 (0xC4 for seq0, dur 0100), overflow clears, the second read has ovf=0, seq values run 0,1,2,3,0…
- Abort: drop spi_cs_n after 7 sck. Require count unchanged and note_rdy=1; the next full frame re-sends identical bytes.
- Full plus simultaneous push/pop: FIFO full and new_note coincides with the pop cycle. Require count stays 8, overflow=0, new event present at the tail.
- Reset mid-frame: assert reset after 10 sck. Require sdo=0, count=0, seq=0, FSM IDLE; a frame after release returns 0x0000. With NOTE_TX_CRC_EN, the single-event test expects byte2 = CRC-8(0x2A,0x84).

Source files
------------

// File: rtl/note_tx_pkg.sv
// Shared types and constants for the note event SPI return path.
// Build option: define NOTE_TX_CRC_EN to append a CRC-8 byte to each frame.
package note_tx_pkg;

  localparam int EVT_NOTE_W = 8;
  localparam int EVT_DUR_W  = 4;
  localparam int SEQ_W      = 2;

`ifdef NOTE_TX_CRC_EN
  localparam int FRAME_BITS = 24;
`else
  localparam int FRAME_BITS = 16;
`endif

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef struct packed {
    logic [EVT_NOTE_W-1:0] note;
    logic [EVT_DUR_W-1:0]  dur;
    logic [SEQ_W-1:0]      seq;
  } note_evt_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } tx_state_t;

`ifdef NOTE_TX_CRC_EN
  // MSB-first CRC-8, init 0, no reflection.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ d[i])
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else
        c = {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/note_evt_fifo.sv
// Synchronous event FIFO; a pop frees a slot for a push in the same cycle.
// Depth must be a power of two, at least 2.
module note_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/note_spi_tx.sv
// SPI-slave return path: queues note events and sends one per CS frame.
// Build option: NOTE_TX_CRC_EN adds a CRC-8 third byte (24-bit frame).
module note_spi_tx
  import note_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int NOTE_W      = 8,
  parameter int DUR_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        new_note,
  input  logic [NOTE_W-1:0]           note,
  input  logic [DUR_W-1:0]            note_dur,
  input  logic                        sck,
  input  logic                        spi_cs_n,
  output logic                        sdo,
  output logic                        note_rdy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int EW = $bits(note_evt_t);
  localparam int BW = EVT_NOTE_W + EVT_DUR_W + SEQ_W + 2;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   cs_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  tx_state_t              state;
  logic [FRAME_BITS-2:0]  sr;
  logic [CW-1:0]          bitcnt;
  logic                   sent_valid;
  logic                   sent_ovf;
  logic [SEQ_W-1:0]       seq;

  note_evt_t              evt_in;
  note_evt_t              head;
  logic [EW-1:0]          head_raw;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   drop;
  logic [BW-1:0]          base_word;
  logic [FRAME_BITS-1:0]  frame_word;

  // Chains reset low so a CS already asserted at release never looks like a fall.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sck_sync <= '0;
      cs_sync  <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  assign evt_in = '{note: note, dur: note_dur, seq: seq};
  assign head   = note_evt_t'(head_raw);
  assign pop    = (state == DONE) & cs_rise & sent_valid;
  assign drop   = new_note & fifo_full & ~pop;

  note_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (reset),
    .push  (new_note),
    .din   (evt_in),
    .pop   (pop),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    base_word = '0;
    if (!fifo_empty)
      base_word = {head.note, 1'b1, overflow, head.seq, head.dur};
  end

`ifdef NOTE_TX_CRC_EN
  assign frame_word = {base_word, crc8(base_word)};
`else
  assign frame_word = base_word;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      sdo        <= 1'b0;
      bitcnt     <= '0;
      sent_valid <= 1'b0;
      sent_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (cs_fall)
            state <= LOAD;
        end
        LOAD: begin
          sr         <= frame_word[FRAME_BITS-2:0];
          sdo        <= frame_word[FRAME_BITS-1];
          bitcnt     <= '0;
          sent_valid <= ~fifo_empty;
          sent_ovf   <= overflow & ~fifo_empty;
          state      <= cs_rise ? IDLE : SHIFT;
        end
        SHIFT: begin
          if (cs_rise) begin
            sdo   <= 1'b0;
            state <= IDLE;
          end else if (bitcnt == CW'(FRAME_BITS)) begin
            sdo   <= 1'b0;
            state <= DONE;
          end else begin
            if (sck_rise)
              bitcnt <= bitcnt + 1'b1;
            if (sck_fall) begin
              sdo <= sr[FRAME_BITS-2];
              sr  <= {sr[FRAME_BITS-3:0], 1'b0};
            end
          end
        end
        DONE: begin
          sdo <= 1'b0;
          if (cs_rise)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A drop in the clearing cycle wins, so no overflow goes unreported.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      seq      <= '0;
      overflow <= 1'b0;
      note_rdy <= 1'b0;
    end else begin
      if (new_note & ~drop)
        seq <= seq + 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (pop & sent_ovf)
        overflow <= 1'b0;
      note_rdy <= (fifo_count != '0);
    end
  end

endmodule

// File: tb/tb_note_spi_tx.sv
// Randomised scoreboard bench for note_spi_tx against a queue-level model.
// Frame length follows NOTE_TX_CRC_EN.
module tb_note_spi_tx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
`ifdef NOTE_TX_CRC_EN
  localparam int FB = 24;
`else
  localparam int FB = 16;
`endif

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [1:0] s;
  } evt_t;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       new_note = 1'b0;
  logic [7:0] note = '0;
  logic [3:0] note_dur = '0;
  logic       sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       sdo;
  logic       note_rdy;
  logic [3:0] fifo_count;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  evt_t          m_q[$];
  logic [1:0]    m_seq = '0;
  bit            m_ovf = 1'b0;
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] got_q[$];

  always #5 clk_in = ~clk_in;

  note_spi_tx #(
    .FIFO_DEPTH  (DEPTH),
    .NOTE_W      (8),
    .DUR_W       (4),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .new_note   (new_note),
    .note       (note),
    .note_dur   (note_dur),
    .sck        (sck),
    .spi_cs_n   (spi_cs_n),
    .sdo        (sdo),
    .note_rdy   (note_rdy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

`ifdef NOTE_TX_CRC_EN
  function automatic logic [7:0] ref_crc(input logic [15:0] w);
    logic [7:0] c = 8'h00;
    for (int b = 1; b >= 0; b--) begin
      c ^= w[b*8 +: 8];
      for (int k = 0; k < 8; k++)
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  function automatic logic [FB-1:0] model_word();
    logic [15:0] w = 16'h0000;
    if (m_q.size() != 0)
      w = {m_q[0].n, 1'b1, m_ovf, m_q[0].s, m_q[0].d};
`ifdef NOTE_TX_CRC_EN
    return {w, ref_crc(w)};
`else
    return w;
`endif
  endfunction

  function automatic void model_push(input logic [7:0] n, input logic [3:0] d);
    if (m_q.size() < DEPTH) begin
      m_q.push_back('{n, d, m_seq});
      m_seq++;
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  task automatic push(input logic [7:0] n, input logic [3:0] d);
    @(negedge clk_in);
    new_note = 1'b1;
    note     = n;
    note_dur = d;
    @(negedge clk_in);
    new_note = 1'b0;
    model_push(n, d);
  endtask

  // nbits < FB gives an aborted frame; co_push lands a push on the pop cycle.
  task automatic frame(input int nbits, input bit co_push,
                       input logic [7:0] cn, input logic [3:0] cd);
    logic [FB-1:0] rx = '0;
    bit full_f = (nbits == FB);
    bit valid_s = (m_q.size() != 0);
    bit ovf_s = m_ovf & valid_s;
    if (full_f)
      exp_q.push_back(model_word());
    @(negedge clk_in);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk_in);
    for (int i = 0; i < nbits; i++) begin
      rx  = {rx[FB-2:0], sdo};
      sck = 1'b1;
      repeat (6) @(negedge clk_in);
      sck = 1'b0;
      repeat (6) @(negedge clk_in);
    end
    spi_cs_n = 1'b1;
    if (co_push) begin
      repeat (SYNC) @(posedge clk_in);
      @(negedge clk_in);
      new_note = 1'b1;
      note     = cn;
      note_dur = cd;
      @(negedge clk_in);
      new_note = 1'b0;
    end
    if (full_f) begin
      got_q.push_back(rx);
      if (valid_s)
        void'(m_q.pop_front());
      if (ovf_s)
        m_ovf = 1'b0;
      if (co_push)
        model_push(cn, cd);
    end
    repeat (8) @(negedge clk_in);
  endtask

  task automatic chk_state(input string tag);
    repeat (3) @(negedge clk_in);
    chk({tag, ".count"}, fifo_count, m_q.size());
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".rdy"}, note_rdy, m_q.size() != 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    sck      = 1'b0;
    repeat (4) @(negedge clk_in);
    reset = 1'b0;
    m_q.delete();
    m_seq = '0;
    m_ovf = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    forever begin
      wait (got_q.size() != 0);
      begin
        logic [FB-1:0] g;
        g = got_q.pop_front();
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL frame: got %0h with nothing expected", g);
        end else begin
          chk("frame", g, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk_in);
    reset = 1'b0;
    m_q.delete();
    @(negedge clk_in);
    chk("rst.sdo", sdo, 0);
    chk_state("rst");

    push(8'h2A, 4'b0100);
    chk_state("single.pre");
    frame(FB, 1'b0, '0, '0);
    chk_state("single.post");

    frame(FB, 1'b0, '0, '0);
    chk_state("empty");

    do_reset();
    push(8'h2A, 4'b0100);
    for (int i = 1; i < 9; i++)
      push(8'(8'h30 + i), 4'(i));
    chk_state("ovf.fill");
    frame(FB, 1'b0, '0, '0);
    chk_state("ovf.rd1");
    frame(FB, 1'b0, '0, '0);
    chk_state("ovf.rd2");

    frame(7, 1'b0, '0, '0);
    chk_state("abort");
    frame(FB, 1'b0, '0, '0);
    chk_state("abort.resend");

    while (m_q.size() < DEPTH)
      push(8'($urandom), 4'($urandom));
    chk_state("full");
    frame(FB, 1'b1, 8'h77, 4'h9);
    chk_state("full.pushpop");
    for (int i = 0; i < DEPTH; i++)
      frame(FB, 1'b0, '0, '0);
    chk_state("full.drain");

    push(8'h55, 4'h5);
    push(8'h66, 4'h6);
    @(negedge clk_in);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk_in);
    for (int i = 0; i < 10; i++) begin
      sck = 1'b1;
      repeat (6) @(negedge clk_in);
      sck = 1'b0;
      repeat (6) @(negedge clk_in);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("midrst.sdo", sdo, 0);
    chk("midrst.count", fifo_count, 0);
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    m_q.delete();
    m_seq = '0;
    m_ovf = 1'b0;
    repeat (6) @(negedge clk_in);
    frame(FB, 1'b0, '0, '0);
    push(8'h11, 4'h3);
    frame(FB, 1'b0, '0, '0);
    chk_state("midrst.after");

    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 4) begin
        int k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++)
          push(8'($urandom), 4'($urandom));
      end else if (r < 8) begin
        frame(FB, 1'b0, '0, '0);
      end else begin
        frame($urandom_range(1, FB - 1), 1'b0, '0, '0);
      end
      chk_state("rand");
    end

    for (int i = 0; i < 2000 && (got_q.size() != 0 || exp_q.size() != 0); i++)
      @(negedge clk_in);
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d exp %0d left, want 0", got_q.size(), exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
